// File: rtl/instr_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg: shared definitions for the instruction sequencer.
//   - opcode constants and the R-type / I-type opcode ranges
//   - sequencer state encoding
//   - bit positions of the instruction word fields
// Instruction word layout: opcode[15:12] rc[11:8] ra[7:4] rb[3:0]
// -----------------------------------------------------------------------------
package seq_pkg;

  // R-type opcodes (rc <- ra op rb)
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  // I-type opcodes (rc <- imm op rb); ra field carries the immediate
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_SUBI = 4'd7;
  localparam logic [3:0] OP_ANDI = 4'd8;
  localparam logic [3:0] OP_ORI  = 4'd9;
  localparam logic [3:0] OP_10   = 4'd10;

  // Opcode range limits; anything above I_LAST is undefined
  localparam logic [3:0] R_LAST  = 4'd5;
  localparam logic [3:0] I_FIRST = 4'd6;
  localparam logic [3:0] I_LAST  = 4'd10;

  // Field slice positions
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RC_HI = 11;
  localparam int RC_LO = 8;
  localparam int RA_HI = 7;
  localparam int RA_LO = 4;
  localparam int RB_HI = 3;
  localparam int RB_LO = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;

endpackage

// File: rtl/instr_sequencer_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder: purely combinational instruction decode.
// Ports:
//   i_instr      in  16  instruction word
//   o_reg_a      out 4   bank read address A (0 for I-type)
//   o_reg_b      out 4   bank read address B
//   o_reg_c      out 4   bank write address
//   o_imm        out 16  zero-extended immediate (0 for R-type)
//   o_flag_imm   out 1   select immediate operand
//   o_alu_op     out 4   ALU opcode
//   o_is_illegal out 1   opcode outside the defined ranges
// Outputs for an illegal opcode are don't-care; the sequencer never latches
// them.
// -----------------------------------------------------------------------------
module instr_decoder
  import seq_pkg::*;
(
  input  logic [15:0] i_instr,
  output logic [3:0]  o_reg_a,
  output logic [3:0]  o_reg_b,
  output logic [3:0]  o_reg_c,
  output logic [15:0] o_imm,
  output logic        o_flag_imm,
  output logic [3:0]  o_alu_op,
  output logic        o_is_illegal
);

  logic [3:0] w_op;
  assign w_op = i_instr[OP_HI:OP_LO];

  always_comb begin
    o_reg_a      = 4'd0;
    o_reg_b      = i_instr[RB_HI:RB_LO];
    o_reg_c      = i_instr[RC_HI:RC_LO];
    o_imm        = 16'd0;
    o_flag_imm   = 1'b0;
    o_alu_op     = w_op;
    o_is_illegal = 1'b0;
    if (w_op <= R_LAST) begin
      o_reg_a = i_instr[RA_HI:RA_LO];
    end else if ((w_op >= I_FIRST) && (w_op <= I_LAST)) begin
      // ra field is reused as a 4-bit unsigned immediate
      o_imm      = {12'd0, i_instr[RA_HI:RA_LO]};
      o_flag_imm = 1'b1;
    end else begin
      o_is_illegal = 1'b1;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer: multi-cycle control FSM for the 16-bit datapath.
// Accepts one instruction per valid/ready handshake in IDLE, decodes it in
// DECODE, waits EXEC_CYCLES for the registered ALU result, then pulses the
// bank write enable for one cycle in WB.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   instr_valid   instruction word available
//   instr         instruction word
//   instr_ready   sequencer idle and able to accept
//   reg_a/b/c     bank addresses (held from first EXEC cycle until next DECODE)
//   imm, flag_imm immediate operand and its select
//   alu_op        ALU opcode
//   reg_we, done  one-cycle pulse in WB
//   illegal       one-cycle pulse after decoding an undefined opcode
//   busy          instruction in flight
//   instr_count   retired instruction count, wraps
// -----------------------------------------------------------------------------
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int EXEC_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [15:0]      instr,
  output logic             instr_ready,
  output logic [3:0]       reg_a,
  output logic [3:0]       reg_b,
  output logic [3:0]       reg_c,
  output logic [15:0]      imm,
  output logic             flag_imm,
  output logic [3:0]       alu_op,
  output logic             reg_we,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  // A non-positive EXEC_CYCLES still needs one cycle for the ALU register
  localparam int EXEC_N = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
  localparam int EW     = $clog2(EXEC_N + 1);
  localparam logic [EW-1:0] EXEC_LAST = EW'(EXEC_N - 1);

  state_t           r_state;
  logic [15:0]      r_ir;
  logic [EW-1:0]    r_exec_cnt;
  logic             r_instr_ready;
  logic [3:0]       r_reg_a;
  logic [3:0]       r_reg_b;
  logic [3:0]       r_reg_c;
  logic [15:0]      r_imm;
  logic             r_flag_imm;
  logic [3:0]       r_alu_op;
  logic             r_reg_we;
  logic             r_busy;
  logic             r_done;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instr_count;

  logic [3:0]  w_reg_a;
  logic [3:0]  w_reg_b;
  logic [3:0]  w_reg_c;
  logic [15:0] w_imm;
  logic        w_flag_imm;
  logic [3:0]  w_alu_op;
  logic        w_is_illegal;

  instr_decoder u_decoder (
    .i_instr      (r_ir),
    .o_reg_a      (w_reg_a),
    .o_reg_b      (w_reg_b),
    .o_reg_c      (w_reg_c),
    .o_imm        (w_imm),
    .o_flag_imm   (w_flag_imm),
    .o_alu_op     (w_alu_op),
    .o_is_illegal (w_is_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ir          <= 16'd0;
      r_exec_cnt    <= '0;
      r_instr_ready <= 1'b1;
      r_reg_a       <= 4'd0;
      r_reg_b       <= 4'd0;
      r_reg_c       <= 4'd0;
      r_imm         <= 16'd0;
      r_flag_imm    <= 1'b0;
      r_alu_op      <= 4'd0;
      r_reg_we      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_illegal     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      // Pulse outputs default low; only the state that owns them raises them
      r_reg_we  <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_ir          <= instr;
            r_state       <= S_DECODE;
            r_instr_ready <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        S_DECODE: begin
          if (w_is_illegal) begin
            // Drop the instruction; decoded outputs keep their old values
            r_illegal     <= 1'b1;
            r_state       <= S_IDLE;
            r_instr_ready <= 1'b1;
            r_busy        <= 1'b0;
          end else begin
            r_reg_a    <= w_reg_a;
            r_reg_b    <= w_reg_b;
            r_reg_c    <= w_reg_c;
            r_imm      <= w_imm;
            r_flag_imm <= w_flag_imm;
            r_alu_op   <= w_alu_op;
            r_exec_cnt <= '0;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Raise the write-back pulses on the edge into WB so they are
          // visible during exactly the WB cycle
          if (r_exec_cnt == EXEC_LAST) begin
            r_state       <= S_WB;
            r_reg_we      <= 1'b1;
            r_done        <= 1'b1;
            r_instr_count <= r_instr_count + CNT_W'(1);
          end else begin
            r_exec_cnt <= r_exec_cnt + EW'(1);
          end
        end
        S_WB: begin
          r_state       <= S_IDLE;
          r_instr_ready <= 1'b1;
          r_busy        <= 1'b0;
        end
        default: begin
          r_state       <= S_IDLE;
          r_instr_ready <= 1'b1;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = r_instr_ready;
  assign reg_a       = r_reg_a;
  assign reg_b       = r_reg_b;
  assign reg_c       = r_reg_c;
  assign imm         = r_imm;
  assign flag_imm    = r_flag_imm;
  assign alu_op      = r_alu_op;
  assign reg_we      = r_reg_we;
  assign busy        = r_busy;
  assign done        = r_done;
  assign illegal     = r_illegal;
  assign instr_count = r_instr_count;

endmodule
